// File: rtl/dmem_controller_pkg.sv
// Shared types and constants for the data-memory controller: access-size encodings,
// request payload layout and the alignment/legality check.
package dmem_controller_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned MODE_W = 4;

  localparam logic [MODE_W-1:0] RW_BYTE     = 4'h0;
  localparam logic [MODE_W-1:0] RW_HALFWORD = 4'h1;
  localparam logic [MODE_W-1:0] RW_WORD     = 4'h2;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [MODE_W-1:0] rw_mode;
    logic              wr_en;
    logic              load_unsigned;
  } dmem_req_t;

  // True when the size encoding is illegal or the byte offset is misaligned for it.
  function automatic logic access_fault(input logic [MODE_W-1:0] mode, input logic [1:0] off);
    case (mode)
      RW_BYTE:     access_fault = 1'b0;
      RW_HALFWORD: access_fault = off[0];
      RW_WORD:     access_fault = (off != 2'b00);
      default:     access_fault = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane select with sign/zero extension for loads, and
// read-modify-write merge of a byte/halfword into the fetched RAM word for stores.
module dmem_lane_align
  import dmem_controller_pkg::*;
(
  input  logic [MODE_W-1:0] rw_mode,
  input  logic              load_unsigned,
  input  logic [1:0]        byte_off,
  input  logic [XLEN-1:0]   ram_rdata,
  input  logic [15:0]       store_data,
  output logic [XLEN-1:0]   load_c,
  output logic [XLEN-1:0]   merge_c
);

  logic [4:0]  bit_off;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    bit_off   = {byte_off, 3'b000};
    lane_byte = ram_rdata[bit_off +: 8];
    lane_half = byte_off[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    load_c    = ram_rdata;
    merge_c   = ram_rdata;
    case (rw_mode)
      RW_BYTE: begin
        load_c = load_unsigned ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
        merge_c[bit_off +: 8] = store_data[7:0];
      end
      RW_HALFWORD: begin
        load_c = load_unsigned ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
        if (byte_off[1]) begin
          merge_c[31:16] = store_data;
        end else begin
          merge_c[15:0] = store_data;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/dmem_controller.sv
// CPU-to-single-port-RAM data memory controller: byte/halfword/word loads and stores,
// sub-word stores done as read-modify-write, misaligned/illegal accesses flagged.
module dmem_controller
  import dmem_controller_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              wr_en_dmem,
  input  logic [MODE_W-1:0] rw_mode,
  input  logic              load_unsigned,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata,
  output logic              rsp_valid,
  output logic              access_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [XLEN-1:0]   ram_wdata,
  input  logic [XLEN-1:0]   ram_rdata
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MRG  = 3'd2,
    WR   = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  dmem_req_t         req_q, req_d;
  logic              req_ready_d, rsp_valid_d, access_err_d, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [XLEN-1:0]   ram_wdata_q, ram_wdata_d;
  logic [XLEN-1:0]   load_c, merge_c;
  logic              in_mrg_load, in_mrg_store;
  logic              unused_req_bits;

  dmem_lane_align u_lane_align (
    .rw_mode       (req_q.rw_mode),
    .load_unsigned (req_q.load_unsigned),
    .byte_off      (req_q.addr[1:0]),
    .ram_rdata     (ram_rdata),
    .store_data    (req_q.wdata[15:0]),
    .load_c        (load_c),
    .merge_c       (merge_c)
  );

  // Word address and high store bits are consumed elsewhere (ram_addr register, WR path).
  assign unused_req_bits = ^{req_q.addr[XLEN-1:2], req_q.wdata[XLEN-1:16]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_q       <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      access_err  <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state       <= state_nxt;
      req_q       <= req_d;
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      access_err  <= access_err_d;
      ram_we      <= ram_we_d;
      ram_addr    <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Response strobes are registered from the next state so they line up with WR/MRG/ERR.
  always_comb begin
    state_nxt    = state;
    req_d        = req_q;
    ram_addr_d   = ram_addr;
    ram_wdata_d  = ram_wdata_q;
    rdata_d      = rdata_q;
    rsp_valid_d  = 1'b0;
    access_err_d = 1'b0;
    ram_we_d     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_d.addr          = addr;
          req_d.wdata         = wdata;
          req_d.rw_mode       = rw_mode;
          req_d.wr_en         = wr_en_dmem;
          req_d.load_unsigned = load_unsigned;
          ram_addr_d          = addr[ADDR_W+1:2];
          if (access_fault(rw_mode, addr[1:0])) begin
            state_nxt    = ERR;
            rsp_valid_d  = 1'b1;
            access_err_d = 1'b1;
          end else if (wr_en_dmem && (rw_mode == RW_WORD)) begin
            state_nxt   = WR;
            rsp_valid_d = 1'b1;
            ram_we_d    = 1'b1;
            ram_wdata_d = wdata;
          end else begin
            state_nxt = RD;
          end
        end
      end
      RD: begin
        state_nxt   = MRG;
        rsp_valid_d = 1'b1;
        ram_we_d    = req_q.wr_en;
      end
      MRG: begin
        state_nxt = IDLE;
        if (req_q.wr_en) begin
          ram_wdata_d = merge_c;
        end else begin
          rdata_d = load_c;
        end
      end
      WR:      state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    req_ready_d = (state_nxt == IDLE);
  end

  // RAM read data only arrives in MRG, so the merged word and load result bypass
  // their hold registers for that one cycle.
  assign in_mrg_load  = (state == MRG) && !req_q.wr_en;
  assign in_mrg_store = (state == MRG) && req_q.wr_en;
  assign rdata        = in_mrg_load  ? load_c  : rdata_q;
  assign ram_wdata    = in_mrg_store ? merge_c : ram_wdata_q;

endmodule

// File: doc/dmem_controller.md
DMEM_CONTROLLER -- requirements
Module: dmem_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving the RAM word-address width (1024 words).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit: the CPU presents an access.
REQ-005 SHALL have port req_ready, output, 1 bit: the controller accepts an access this cycle.
REQ-006 SHALL have port wr_en_dmem, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port rw_mode, input, 4 bits: access size, one of BYTE, HALFWORD or WORD.
REQ-008 SHALL have port load_unsigned, input, 1 bit: zero-extend loads (funct3[2]).
REQ-009 SHALL have port addr, input, 32 bits: byte address.
REQ-010 SHALL have port wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port rdata, output, 32 bits: extended load result.
REQ-012 SHALL have port rsp_valid, output, 1 bit: access completed; pulses for one cycle.
REQ-013 SHALL have port access_err, output, 1 bit: valid with rsp_valid; set for a misaligned address or an illegal rw_mode.
REQ-014 SHALL have port ram_addr, output, ADDR_W bits: RAM word address.
REQ-015 SHALL have port ram_we, output, 1 bit: RAM word write enable.
REQ-016 SHALL have port ram_wdata, output, 32 bits: RAM write word.
REQ-017 SHALL have port ram_rdata, input, 32 bits: RAM read word, valid one cycle after its address is presented.

Function
REQ-018 SHALL implement FSM states IDLE, RD, MRG, WR and ERR.
REQ-019 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0; requests arriving while not in IDLE are ignored.
REQ-020 On acceptance (req_valid & req_ready), SHALL latch addr, wdata, rw_mode, wr_en_dmem and load_unsigned.
REQ-021 On acceptance, SHALL go to ERR if any of these holds: HALFWORD with addr[0]=1; WORD with addr[1:0]≠0; rw_mode not BYTE/HALFWORD/WORD.
REQ-022 Otherwise, on acceptance, SHALL go to WR for a WORD store, and to RD for any load or any sub-word store.
REQ-023 ERR SHALL assert rsp_valid=1 and access_err=1, never assert ram_we, and return to IDLE.
REQ-024 RD SHALL drive ram_addr=addr[ADDR_W+1:2] with ram_we=0, then go to MRG.
REQ-025 MRG, for a load: rdata <= ram_rdata lane, little-endian. BYTE lane = addr[1:0]*8; HALFWORD lane = addr[1]*16. Sign- or zero-extend per load_unsigned. Assert rsp_valid; go to IDLE.
REQ-026 MRG, for a sub-word store: ram_we=1; ram_wdata = ram_rdata with the addressed byte/halfword replaced by wdata[7:0]/wdata[15:0]. Assert rsp_valid; go to IDLE.
REQ-027 WR SHALL drive ram_we=1 and ram_wdata=wdata, assert rsp_valid, and go to IDLE.
REQ-028 Latency from acceptance to rsp_valid SHALL be 1 cycle for WORD store and ERR, and 2 cycles for loads and sub-word stores.
REQ-029 The next acceptance SHALL occur no earlier than the cycle after rsp_valid.
REQ-030 SHALL ignore address bits above ADDR_W+1; the RAM address wraps.
REQ-031 rdata SHALL hold its value until the next successful load response; stores and errors SHALL leave it unchanged.
REQ-032 ram_we SHALL be 1 only in WR, and in MRG for a store.

Reset
REQ-033 Reset SHALL set state=IDLE, rdata=0, rsp_valid=0, access_err=0, ram_we=0, ram_addr=0, ram_wdata=0 and clear all latched request registers.
REQ-034 Reset asserted mid-access SHALL abort the access immediately: ram_we drops asynchronously and no response is issued.

Structure
REQ-035 BYTE/HALFWORD/WORD encodings SHALL come from common_library.vh.
REQ-036 FSM state encodings SHALL be local to the module.
REQ-037 Lane extraction/extension and store merge SHALL live in one combinational sub-module, dmem_lane_align, used by MRG.

Verification
REQ-038 SW addr=0x8, wdata=0xDEADBEEF -> 1 cycle later ram_we=1, ram_addr=2, ram_wdata=0xDEADBEEF, rsp_valid=1, access_err=0.
REQ-039 RAM[2]=0xDEADBEEF; LB addr=0xB -> rdata=0xFFFFFFDE. LBU -> 0x000000DE. LH addr=0xA -> 0xFFFFDEAD.
REQ-040 RAM[2]=0xDEADBEEF; SB addr=0x9, wdata=0x12 -> RD then MRG; ram_wdata=0xDEAD12EF, rsp_valid 2 cycles after accept.
REQ-041 LW addr=0x6, or rw_mode=4'hF -> rsp_valid=1 and access_err=1 after 1 cycle; ram_we stays 0; rdata unchanged.
REQ-042 rst_n low during RD of an SH -> next cycle state=IDLE, no ram_we pulse, no rsp_valid; RAM contents unchanged.
